// File: rtl/ex_muldiv_if.sv
// Operand/result bundle between the ID/EX operands and the EX mul/div unit.
// The master launches operations; the slave reports busy/done and HI/LO.
interface ex_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             flush;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, flush, op, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, flush, op, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU (shift-add) and DIV/DIVU (restoring) unit
// with HI/LO result registers, one iteration per clock.
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    ex_muldiv_if.slave  mdu
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] opd_q;
    logic             is_div_q;
    logic             neg_q;
    logic             sign_a_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH-1:0]   div_rm;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    logic             sgn_op, sa, sb, b_zero;
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        sgn_op = ~mdu.op[0];
        sa     = sgn_op & mdu.a[WIDTH-1];
        sb     = sgn_op & mdu.b[WIDTH-1];
        mag_a  = sa ? -mdu.a : mdu.a;
        mag_b  = sb ? -mdu.b : mdu.b;
        b_zero = (mdu.b == '0);
    end

    always_comb begin
        add_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opd_q} : '0);
        div_sh  = {acc_q, mq_q[WIDTH-1]};
        div_ge  = (div_sh >= {1'b0, opd_q});
        div_rm  = div_sh[WIDTH-1:0] - opd_q;
        if (is_div_q) begin
            acc_d = div_ge ? div_rm : div_sh[WIDTH-1:0];
            mq_d  = {mq_q[WIDTH-2:0], div_ge};
        end else begin
            acc_d = add_sum[WIDTH:1];
            mq_d  = {add_sum[0], mq_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod_fix = neg_q ? -{acc_q, mq_q} : {acc_q, mq_q};
        quo_fix  = neg_q ? -mq_q : mq_q;
        rem_fix  = sign_a_q ? -acc_q : acc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            opd_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            sign_a_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (mdu.start && !mdu.flush) begin
                        unique case (1'b1)
                            !mdu.op[2]: begin
                                is_div_q <= mdu.op[1];
                                sign_a_q <= sa;
                                // divide by zero keeps the all-ones
                                // quotient and lets the remainder
                                // reconstruct the dividend
                                neg_q    <= (sa ^ sb) &
                                            ~(mdu.op[1] & b_zero);
                                acc_q    <= '0;
                                mq_q     <= mdu.op[1] ? mag_a : mag_b;
                                opd_q    <= mdu.op[1] ? mag_b : mag_a;
                                cnt_q    <= '0;
                                state_q  <= ITER;
                            end
                            mdu.op == 3'b100: hi_q <= mdu.a;
                            mdu.op == 3'b101: lo_q <= mdu.a;
                            default: ;
                        endcase
                    end
                end
                ITER: begin
                    if (mdu.flush) begin
                        state_q <= IDLE;
                    end else begin
                        acc_q <= acc_d;
                        mq_q  <= mq_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(WIDTH - 1))
                            state_q <= FIX;
                    end
                end
                FIX: begin
                    state_q <= IDLE;
                    if (!mdu.flush) begin
                        if (is_div_q) begin
                            lo_q <= quo_fix;
                            hi_q <= rem_fix;
                        end else begin
                            {hi_q, lo_q} <= prod_fix;
                        end
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mdu.busy = (state_q != IDLE);
    assign mdu.done = done_q;
    assign mdu.hi   = hi_q;
    assign mdu.lo   = lo_q;
endmodule
